// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master arbiter slice.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOAD  = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  localparam int unsigned SPCON_CPOL_BIT = 2;
  localparam int unsigned SPCON_CPHA_BIT = 1;

endpackage

// File: rtl/spi_master_arbiter_if.sv
// Client- and core-side signal bundle of the SPI master arbiter.
interface spi_master_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned LEN_W = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*LEN_W-1:0] req_len;
  logic [NREQ*8-1:0]     req_spcon;
  logic [NREQ*8-1:0]     req_tx_data;
  logic [NREQ-1:0]       tx_rd;
  logic [7:0]            rx_data;
  logic [NREQ-1:0]       rx_vld;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic [NREQ-1:0]       ssn_sel;
  logic                  core_start;
  logic [7:0]            core_data;
  logic [7:0]            core_spcon;
  logic                  core_done;
  logic [7:0]            core_data_r;

  modport master (
    input  req, req_len, req_spcon, req_tx_data, core_done, core_data_r,
    output tx_rd, rx_data, rx_vld, grant, done, ssn_sel,
           core_start, core_data, core_spcon
  );

  modport slave (
    output req, req_len, req_spcon, req_tx_data, core_done, core_data_r,
    input  tx_rd, rx_data, rx_vld, grant, done, ssn_sel,
           core_start, core_data, core_spcon
  );
endinterface

// File: rtl/spi_master_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
module rr_arbiter #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            any,
  output logic [PW-1:0]   idx
);

  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      int unsigned j;
      j = (32'(ptr) + i) % NREQ;
      if (!any && req[PW'(j)]) begin
        any = 1'b1;
        idx = PW'(j);
      end
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one byte-level SPI master core between NREQ clients, round-robin per burst.
module spi_master_arbiter
  import spi_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned LEN_W     = 4,
  parameter int unsigned GUARD_CYC = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  spi_master_arbiter_if.master bus
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC + 1) : 1;

  state_t            state, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        spcon_q, spcon_d;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic [NREQ-1:0]   ssn_q, ssn_d;
  logic              start_q, start_d;
  logic [NREQ-1:0]   tx_rd_q, tx_rd_d;
  logic [NREQ-1:0]   rx_vld_q, rx_vld_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic [7:0]        core_data_q, core_data_d;
  logic [7:0]        core_spcon_q, core_spcon_d;

  logic              arb_any;
  logic [PW-1:0]     arb_idx;
  logic [LEN_W-1:0]  len_win;
  logic [7:0]        spcon_win;
  logic [7:0]        tx_own;
  logic [NREQ-1:0]   win_oh;
  logic [NREQ-1:0]   owner_oh;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req (bus.req),
    .ptr (rr_ptr_q),
    .any (arb_any),
    .idx (arb_idx)
  );

  always_comb begin
    len_win   = '0;
    spcon_win = '0;
    tx_own    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_idx == PW'(i)) begin
        len_win   = bus.req_len[i*LEN_W +: LEN_W];
        spcon_win = bus.req_spcon[i*8 +: 8];
      end
      if (owner_q == PW'(i)) tx_own = bus.req_tx_data[i*8 +: 8];
    end
  end

  assign win_oh   = {{(NREQ-1){1'b0}}, 1'b1} << arb_idx;
  assign owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;

  always_comb begin
    state_d      = state;
    grant_d      = grant_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    spcon_d      = spcon_q;
    gcnt_d       = gcnt_q;
    ssn_d        = ssn_q;
    rx_data_d    = rx_data_q;
    core_data_d  = core_data_q;
    core_spcon_d = core_spcon_q;
    start_d      = 1'b0;
    tx_rd_d      = '0;
    rx_vld_d     = '0;
    done_d       = '0;

    unique case (state)
      IDLE: begin
        // Arbitration is skipped while done is visible so a finished client can drop req first.
        if (arb_any && (done_q == '0)) begin
          owner_d  = arb_idx;
          rr_ptr_d = (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + PW'(1);
          cnt_d    = len_win;
          spcon_d  = spcon_win;
          if (len_win == '0) begin
            done_d = win_oh;
          end else begin
            grant_d = win_oh;
            ssn_d   = ~win_oh;
            gcnt_d  = '0;
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        if (gcnt_q == GW'(GUARD_CYC - 1)) state_d = LOAD;
        else                              gcnt_d  = gcnt_q + GW'(1);
      end
      LOAD: begin
        core_data_d  = tx_own;
        core_spcon_d = spcon_q;
        start_d      = 1'b1;
        tx_rd_d      = owner_oh;
        state_d      = WAIT;
      end
      WAIT: begin
        if (bus.core_done) begin
          rx_data_d = bus.core_data_r;
          rx_vld_d  = owner_oh;
          cnt_d     = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            gcnt_d  = '0;
            state_d = HOLD;
          end else begin
            state_d = LOAD;
          end
        end
      end
      HOLD: begin
        if (gcnt_q == GW'(GUARD_CYC - 1)) begin
          ssn_d   = '1;
          done_d  = owner_oh;
          grant_d = '0;
          state_d = IDLE;
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      spcon_q      <= '0;
      gcnt_q       <= '0;
      ssn_q        <= '1;
      start_q      <= 1'b0;
      tx_rd_q      <= '0;
      rx_vld_q     <= '0;
      done_q       <= '0;
      rx_data_q    <= '0;
      core_data_q  <= '0;
      core_spcon_q <= '0;
    end else begin
      state        <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      spcon_q      <= spcon_d;
      gcnt_q       <= gcnt_d;
      ssn_q        <= ssn_d;
      start_q      <= start_d;
      tx_rd_q      <= tx_rd_d;
      rx_vld_q     <= rx_vld_d;
      done_q       <= done_d;
      rx_data_q    <= rx_data_d;
      core_data_q  <= core_data_d;
      core_spcon_q <= core_spcon_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.ssn_sel    = ssn_q;
  assign bus.core_start = start_q;
  assign bus.tx_rd      = tx_rd_q;
  assign bus.rx_vld     = rx_vld_q;
  assign bus.done       = done_q;
  assign bus.rx_data    = rx_data_q;
  assign bus.core_data  = core_data_q;
  assign bus.core_spcon = core_spcon_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Self-checking bench: client/core models, rx/tx scoreboard queues, arbitration vector table.
module tb_spi_master_arbiter;
  import spi_pkg::*;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned LEN_W = 4;
  localparam int unsigned GUARD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_arbiter_if #(.NREQ(NREQ), .LEN_W(LEN_W)) bus ();

  spi_master_arbiter #(.NREQ(NREQ), .LEN_W(LEN_W), .GUARD_CYC(GUARD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0]  b;
    int unsigned own;
  } rx_exp_t;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  len;
    logic [7:0]  spcon;
    int unsigned own;
  } row_t;

  int          total = 0;
  int          bad   = 0;
  rx_exp_t     exp_rx_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [7:0]  exp_spcon = 8'h00;
  logic [7:0]  tx_mem [NREQ][16];
  int unsigned tx_ptr [NREQ];
  int unsigned cfg_gen = 0, seen_gen = 0;
  int unsigned spur_req = 0, spur_done = 0;
  int unsigned core_dly = 0;

  int          cyc = 0;
  int          start_cnt = 0, rxv_cnt = 0, gap_bad = 0, ssn_bad = 0;
  int          last_start = -100, first_start = -1, last_cdone = 0;
  int          ssn_fall = 0, ssn_rise = 0;
  int          done_cnt [NREQ];
  int          grant_log[$];
  logic [3:0]  prev_grant = '0, prev_ssn = '1;
  logic        ssn_any_low = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 99;
  endfunction

  // Client tx source, byte-level core model and output monitors, all on the falling edge.
  initial begin : agent
    logic        pend;
    int unsigned dcnt;
    logic [7:0]  pbyte;
    rx_exp_t     e;
    pend = 1'b0; dcnt = 0; pbyte = '0;
    bus.core_done = 1'b0; bus.core_data_r = '0; bus.req_tx_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (cfg_gen != seen_gen) begin
        seen_gen = cfg_gen;
        for (int i = 0; i < NREQ; i++) tx_ptr[i] = 0;
      end else begin
        for (int i = 0; i < NREQ; i++) if (bus.tx_rd[i]) tx_ptr[i]++;
      end
      for (int i = 0; i < NREQ; i++) bus.req_tx_data[i*8 +: 8] = tx_mem[i][tx_ptr[i] % 16];

      bus.core_done = 1'b0;
      if (spur_req != spur_done) begin
        spur_done++;
        bus.core_done = 1'b1;
        bus.core_data_r = 8'hEE;
      end else if (pend) begin
        if (dcnt == 0) begin
          bus.core_done = 1'b1;
          bus.core_data_r = pbyte;
          pend = 1'b0;
          last_cdone = cyc;
        end else begin
          dcnt--;
        end
      end

      if (bus.core_start) begin
        pend = 1'b1; dcnt = core_dly; pbyte = ~bus.core_data;
        start_cnt++;
        if (first_start < 0) first_start = cyc;
        if (cyc - last_start < 2) gap_bad++;
        last_start = cyc;
        if (exp_tx_q.size() == 0) check("tx_extra_start", 32'd1, 32'd0);
        else check("core_data", {24'd0, bus.core_data}, {24'd0, exp_tx_q.pop_front()});
        check("core_spcon", {24'd0, bus.core_spcon}, {24'd0, exp_spcon});
      end

      if (bus.rx_vld != '0) begin
        rxv_cnt++;
        if (exp_rx_q.size() == 0) check("rx_extra", {28'd0, bus.rx_vld}, 32'd0);
        else begin
          e = exp_rx_q.pop_front();
          check("rx_vld_owner", {28'd0, bus.rx_vld}, 32'd1 << e.own);
          check("rx_data", {24'd0, bus.rx_data}, {24'd0, e.b});
        end
      end

      for (int i = 0; i < NREQ; i++) if (bus.done[i]) done_cnt[i]++;
      if (bus.grant != '0 && prev_grant == '0) grant_log.push_back(oh_idx(bus.grant));
      prev_grant = bus.grant;
      if ($countones(~bus.ssn_sel) > 1) ssn_bad++;
      if (bus.ssn_sel != '1) ssn_any_low = 1'b1;
      if (prev_ssn == '1 && bus.ssn_sel != '1) ssn_fall = cyc;
      if (prev_ssn != '1 && bus.ssn_sel == '1) ssn_rise = cyc;
      prev_ssn = bus.ssn_sel;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    start_cnt = 0; rxv_cnt = 0; gap_bad = 0; first_start = -1; ssn_any_low = 1'b0;
    grant_log.delete();
    for (int i = 0; i < NREQ; i++) done_cnt[i] = 0;
  endtask

  task automatic wait_done(input int lim, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (bus.done != '0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic push_burst(input int unsigned own, input int unsigned n, input int unsigned first);
    logic [7:0] b;
    for (int unsigned k = 0; k < n; k++) begin
      b = tx_mem[own][first + k];
      exp_tx_q.push_back(b);
      exp_rx_q.push_back('{b: ~b, own: own});
    end
  endtask

  task automatic run_row(input row_t r, input int idx);
    logic ok;
    clear_mon();
    cfg_gen++;
    exp_spcon = r.spcon;
    push_burst(r.own, 32'(r.len), 0);
    bus.req_len   = {4{r.len}};
    bus.req_spcon = {4{r.spcon}};
    bus.req       = r.req;
    wait_done(600, ok);
    check($sformatf("row%0d_done_seen", idx), {31'd0, ok}, 32'd1);
    check($sformatf("row%0d_done_owner", idx), {28'd0, bus.done}, 32'd1 << r.own);
    bus.req = '0;
    tick(3);
    check($sformatf("row%0d_starts", idx), start_cnt, 32'(r.len));
    check($sformatf("row%0d_rx_cnt", idx), rxv_cnt, 32'(r.len));
    check($sformatf("row%0d_done_cnt", idx), done_cnt[r.own], 32'd1);
    check($sformatf("row%0d_gap", idx), gap_bad, 32'd0);
    check($sformatf("row%0d_rx_left", idx), exp_rx_q.size(), 32'd0);
    if (r.len == 4'd0) check($sformatf("row%0d_no_ssn", idx), {31'd0, ssn_any_low}, 32'd0);
    else check($sformatf("row%0d_grant", idx), (grant_log.size() > 0) ? grant_log[0] : 99, r.own);
  endtask

  initial begin : main
    row_t rows [9];
    logic ok;
    int   seen;

    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < 16; k++) tx_mem[i][k] = 8'(i * 37 + k * 11 + 1);
    tx_mem[1][0] = 8'hA5; tx_mem[1][1] = 8'h3C; tx_mem[1][2] = 8'hF0;

    rows[0] = '{req: 4'b0101, len: 4'd2,  spcon: 8'h04, own: 0};
    rows[1] = '{req: 4'b0010, len: 4'd3,  spcon: 8'h06, own: 1};
    rows[2] = '{req: 4'b1001, len: 4'd1,  spcon: 8'h02, own: 3};
    rows[3] = '{req: 4'b1001, len: 4'd1,  spcon: 8'h00, own: 0};
    rows[4] = '{req: 4'b0101, len: 4'd2,  spcon: 8'h31, own: 2};
    rows[5] = '{req: 4'b0011, len: 4'd1,  spcon: 8'h02, own: 0};
    rows[6] = '{req: 4'b0100, len: 4'd0,  spcon: 8'h06, own: 2};
    rows[7] = '{req: 4'b1111, len: 4'd1,  spcon: 8'h04, own: 3};
    rows[8] = '{req: 4'b1110, len: 4'd15, spcon: 8'h81, own: 1};

    bus.req = '0; bus.req_len = '0; bus.req_spcon = '0;
    rst_n = 1'b0;
    tick(3);
    check("rst_grant",      {28'd0, bus.grant},      32'h0);
    check("rst_ssn",        {28'd0, bus.ssn_sel},    32'hF);
    check("rst_core_start", {31'd0, bus.core_start}, 32'h0);
    check("rst_tx_rd",      {28'd0, bus.tx_rd},      32'h0);
    check("rst_rx_vld",     {28'd0, bus.rx_vld},     32'h0);
    check("rst_done",       {28'd0, bus.done},       32'h0);
    check("rst_rx_data",    {24'd0, bus.rx_data},    32'h0);
    check("rst_core_data",  {24'd0, bus.core_data},  32'h0);
    check("rst_core_spcon", {24'd0, bus.core_spcon}, 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Reset in the middle of WAIT with a slow core.
    clear_mon();
    cfg_gen++;
    core_dly = 20;
    exp_spcon = 8'h02;
    exp_tx_q.push_back(tx_mem[1][0]);
    bus.req_len = {4{4'd5}}; bus.req_spcon = {4{8'h02}}; bus.req = 4'b0010;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (start_cnt > 0) ok = 1'b1;
    end
    check("midrst_start_seen", {31'd0, ok}, 32'd1);
    tick(5);
    rst_n = 1'b0;
    tick(1);
    check("midrst_ssn",       {28'd0, bus.ssn_sel},   32'hF);
    check("midrst_grant",     {28'd0, bus.grant},     32'h0);
    check("midrst_core_data", {24'd0, bus.core_data}, 32'h0);
    rst_n = 1'b1;
    bus.req = '0;
    tick(25);
    check("midrst_no_done", done_cnt[1], 32'd0);
    check("midrst_no_rx",   rxv_cnt,     32'd0);
    check("midrst_starts",  start_cnt,   32'd1);
    core_dly = 0;

    for (int i = 0; i < 9; i++) begin
      run_row(rows[i], i);
      if (i == 1) begin
        check("t2_ssn_lead", {31'd0, (first_start - ssn_fall) >= int'(GUARD)}, 32'd1);
        check("t2_ssn_tail", {31'd0, (ssn_rise - last_cdone) >= int'(GUARD)}, 32'd1);
      end
    end

    // Round robin with all requests held.
    rst_n = 1'b0; tick(2); rst_n = 1'b1;
    clear_mon(); cfg_gen++;
    exp_spcon = 8'h00;
    push_burst(0, 1, 0); push_burst(1, 1, 0); push_burst(2, 1, 0);
    push_burst(3, 1, 0); push_burst(0, 1, 1);
    bus.req_len = {4{4'd1}}; bus.req_spcon = '0; bus.req = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      wait_done(100, ok);
      check($sformatf("rr_done%0d_seen", b), {31'd0, ok}, 32'd1);
    end
    bus.req = '0;
    tick(3);
    check("rr_log_size", grant_log.size(), 32'd5);
    for (int b = 0; b < 5; b++)
      check($sformatf("rr_grant%0d", b), (grant_log.size() > b) ? grant_log[b] : 99, b % 4);
    check("rr_rx_left", exp_rx_q.size(), 32'd0);

    // Request drop and spcon change mid-burst are ignored.
    clear_mon(); cfg_gen++;
    exp_spcon = 8'h02;
    push_burst(0, 4, 0);
    bus.req_len = {4{4'd4}}; bus.req_spcon = {4{8'h02}}; bus.req = 4'b0001;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (bus.rx_vld != '0) ok = 1'b1;
    end
    check("chg_first_rx", {31'd0, ok}, 32'd1);
    bus.req = '0; bus.req_spcon = {4{8'h06}};
    wait_done(200, ok);
    check("chg_done_seen", {31'd0, ok}, 32'd1);
    tick(3);
    check("chg_starts", start_cnt, 32'd4);
    check("chg_rx_cnt", rxv_cnt,   32'd4);
    check("chg_spcon",  {24'd0, bus.core_spcon}, 32'h02);

    // Spurious core_done in IDLE, SETUP and HOLD.
    clear_mon();
    spur_req++;
    tick(4);
    check("spur_idle_rx", rxv_cnt, 32'd0);
    cfg_gen++;
    exp_spcon = 8'h80;
    push_burst(3, 2, 0);
    bus.req_len = {4{4'd2}}; bus.req_spcon = {4{8'h80}}; bus.req = 4'b1000;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (bus.grant != '0) ok = 1'b1;
    end
    check("spur_grant_seen", {31'd0, ok}, 32'd1);
    spur_req++;
    seen = 0;
    for (int k = 0; k < 100 && seen < 2; k++) begin
      @(negedge clk);
      if (bus.rx_vld != '0) seen++;
    end
    check("spur_rx_two", seen, 32'd2);
    spur_req++;
    wait_done(20, ok);
    check("spur_done_seen", {31'd0, ok}, 32'd1);
    bus.req = '0;
    tick(4);
    check("spur_starts",  start_cnt, 32'd2);
    check("spur_rx_cnt",  rxv_cnt,   32'd2);
    check("spur_done_cnt", done_cnt[3], 32'd1);
    check("ssn_onehot_low", ssn_bad, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
- Shares one byte-level SPI master core between NREQ requesters using round-robin arbitration.
- Per granted burst: latches the requester's length and spcon, drives that requester's slave select low, and feeds bytes to the core one at a time.
- Returns received bytes to the owner, releases the slave select, then re-arbitrates.
- Sits between system-side clients and the SPI master core; the core itself is a separate block.

Parameters:
- NREQ, 4, number of requesters (2..8)
- LEN_W, 4, burst length width; maximum 2^LEN_W-1 bytes per burst
- GUARD_CYC, 2, clk cycles between ssn falling and the first start, and between the last done and ssn rising (>=1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req  in  NREQ  per-requester burst request (level)
- req_len  in  NREQ*LEN_W  burst byte count; slice i belongs to requester i
- req_spcon  in  NREQ*8  spcon per requester; bits [2:1] are {cpol,cpha}, other bits passed through
- req_tx_data  in  NREQ*8  next tx byte per requester
- tx_rd  out  NREQ  one-hot 1-cycle pulse: owner's current tx byte was taken, present the next one
- rx_data  out  8  received byte
- rx_vld  out  NREQ  one-hot 1-cycle pulse qualifying rx_data for the owner
- grant  out  NREQ  one-hot, owner of the current burst
- done  out  NREQ  one-hot 1-cycle pulse at burst end
- ssn_sel  out  NREQ  per-slave select, active low
- core_start  out  1  1-cycle pulse launching one byte transfer
- core_data  out  8  tx byte to core
- core_spcon  out  8  spcon to core
- core_done  in  1  1-cycle pulse: core finished the byte
- core_data_r  in  8  byte received by core, valid with core_done

Behaviour:
Reset and state:
- All logic updates on posedge clk only; rst_n low at an edge is a synchronous reset.
- Reset values: grant=0, ssn_sel=all 1, core_start=0, tx_rd=0, rx_vld=0, done=0, rx_data=0, core_data=0, core_spcon=0.
- Reset also sets rr_ptr=0, FSM=IDLE, and clears the byte counter.
- Reset mid-burst drops ssn_sel high on the next edge. No done pulse is issued.

FSM states: IDLE, SETUP, LOAD, WAIT, HOLD.
- IDLE:
  - If any req is set, pick the first set bit scanning from rr_ptr upward with wrap.
  - Register grant, latch len and spcon, and set rr_ptr = winner+1 mod NREQ.
  - If latched len==0: pulse done for the winner next cycle, clear grant, stay IDLE. ssn is never asserted.
  - Otherwise drive ssn_sel[winner]=0 and go to SETUP.
- SETUP: count GUARD_CYC cycles, then go to LOAD.
- LOAD (1 cycle):
  - core_data <= owner's req_tx_data, core_spcon <= latched spcon.
  - Pulse core_start and tx_rd[owner] together, then go to WAIT.
- WAIT:
  - On core_done: rx_data <= core_data_r, pulse rx_vld[owner] next cycle, decrement count.
  - If count becomes 0, go to HOLD. Otherwise go to LOAD.
  - Minimum gap between consecutive core_start pulses is 2 cycles.
- HOLD:
  - Count GUARD_CYC cycles, then drive ssn_sel[owner]=1, pulse done[owner], clear grant, go to IDLE.
  - Earliest re-arbitration is the cycle after done.

Ownership and spcon:
- req deassert during a burst is ignored; the burst runs to completion.
- Other requests wait; there is no preemption.
- spcon and len are latched at grant; changes during the burst are ignored.
- Byte count is LEN_W bits. len = 2^LEN_W-1 must not wrap.

Ignored and held events:
- core_done outside WAIT is ignored.
- core_done in the same cycle as core_start cannot occur, because core_start is only driven in LOAD.
- A requester still holding req after its done re-competes from the new rr_ptr. It therefore loses to any other pending requester.

Output invariants:
- At most one ssn_sel bit is low at any time.
- grant stays one-hot while the FSM is not in IDLE.

Decomposition:
- Shared package spi_pkg holds:
  - state encoding localparams: IDLE=0, SETUP=1, LOAD=2, WAIT=3, HOLD=4
  - SPCON_CPOL_BIT=2, SPCON_CPHA_BIT=1
- One natural sub-module, rr_arbiter: combinational pick of the first set bit from a pointer with wrap, parameterised by NREQ.
- The FSM, counters and muxing stay in spi_master_arbiter.

Test Plan:
1. Reset mid-WAIT with a core model answering core_done 20 cycles after start -> ssn_sel=4'b1111 the cycle after the reset edge; no done; next grant goes to requester 0.
2. Single burst: req=4'b0010, len[1]=3, tx bytes A5,3C,F0, core echoes bytes inverted -> 3 core_start pulses ≥2 cycles apart; rx_vld[1] with 5A,C3,0F; ssn_sel[1] low from ≥GUARD_CYC cycles before the first start to ≥GUARD_CYC cycles after the last done; one done[1].
3. Round-robin: req=4'b1111 held, all len=1 -> grant order 0,1,2,3,0; never two ssn_sel bits low.
4. len=0 on requester 2 alone -> done[2] pulse, ssn_sel stays 4'b1111, no core_start; rr_ptr advances to 3.
5. Mid-burst changes: requester 0 drops req after the first byte of a len=4 burst, and spcon changes 8'h02→8'h06 mid-burst -> 4 bytes still transferred; core_spcon stays 8'h02 throughout.
6. Spurious core_done in IDLE, SETUP and HOLD -> no rx_vld, byte count unaffected.
